// File: rtl/limn2600_pkg.sv
// Shared definitions for the limn2600 memory-mapped interval timer.
package limn2600_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned CTRL_W = 3;

   // Register select values taken from addr[3:2]
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_RELOAD = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int unsigned CTRL_EN   = 0;
   localparam int unsigned CTRL_IE   = 1;
   localparam int unsigned CTRL_AUTO = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_HOLD = 2'd2
   } bus_state_t;

endpackage

// File: rtl/limn2600_timer_prescaler.sv
// Divides clk by PRESCALE while enabled; o_tick_c marks the wrap cycle.
module limn2600_timer_prescaler #(
   parameter int unsigned PRESCALE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_clr,
   output logic o_tick_c
);

   localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  r_cnt <= '0;
      else if (i_clr || !i_en)   r_cnt <= '0;
      else if (r_cnt == LAST)    r_cnt <= '0;
      else                       r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_tick_c = i_en & (r_cnt == LAST);

endmodule

// File: rtl/limn2600_bus_timer.sv
// Interval timer bus responder: bus handshake FSM, register file and
// 32-bit down-counter with one-shot/periodic modes and level interrupt.
module limn2600_bus_timer
   import limn2600_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'hF000_0000,
   parameter int unsigned PRESCALE  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic              we,
   input  logic              oe,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              rdy,
   output logic              irq
);

   bus_state_t        r_state, w_state_nxt;
   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_reload, r_count, r_data_out, w_rd_data;
   logic              r_exp, r_rdy, r_irq;
   logic              w_sel, w_acc, w_wr, w_tick_c, w_tick, w_expire;
   logic              w_wr_ctrl, w_wr_reload, w_wr_count, w_wr_status;
   logic [1:0]        w_reg;
   logic              w_unused;

   assign w_sel       = ce & (addr[31:4] == BASE_ADDR[31:4]);
   assign w_acc       = (r_state == ST_IDLE) & w_sel;
   assign w_wr        = w_acc & we;
   assign w_reg       = addr[3:2];
   assign w_wr_ctrl   = w_wr & (w_reg == REG_CTRL);
   assign w_wr_reload = w_wr & (w_reg == REG_RELOAD);
   assign w_wr_count  = w_wr & (w_reg == REG_COUNT);
   assign w_wr_status = w_wr & (w_reg == REG_STATUS);
   assign w_unused    = ^addr[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= ST_IDLE;
      else      r_state <= w_state_nxt;
   end

   // One acceptance per ce assertion: ACK for a single cycle, then HOLD until ce drops
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_sel) w_state_nxt = ST_ACK;
         ST_ACK:  w_state_nxt = ce ? ST_HOLD : ST_IDLE;
         ST_HOLD: if (!ce) w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_rd_data = '0;
      unique case (w_reg)
         REG_CTRL:   w_rd_data = DATA_W'(r_ctrl);
         REG_RELOAD: w_rd_data = r_reload;
         REG_COUNT:  w_rd_data = r_count;
         REG_STATUS: w_rd_data = DATA_W'(r_exp);
         default:    w_rd_data = '0;
      endcase
   end

   limn2600_timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .i_en     (r_ctrl[CTRL_EN]),
      .i_clr    (w_wr_count),
      .o_tick_c (w_tick_c)
   );

   // A COUNT write, or a CTRL write that clears EN, swallows a coincident tick
   assign w_tick   = w_tick_c & ~w_wr_count & ~(w_wr_ctrl & ~data_in[CTRL_EN]);
   assign w_expire = w_tick & (r_count == DATA_W'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ctrl   <= '0;
         r_reload <= '0;
         r_count  <= '0;
         r_exp    <= 1'b0;
      end else begin
         if (w_wr_reload) r_reload <= data_in;

         if (w_wr_count) begin
            r_count <= data_in;
         end else if (w_tick) begin
            if (r_count > DATA_W'(1))
               r_count <= r_count - DATA_W'(1);
            else if (r_count == DATA_W'(1))
               r_count <= r_ctrl[CTRL_AUTO] ? r_reload : '0;
            else if (r_ctrl[CTRL_AUTO])
               r_count <= r_reload;
         end

         // Reaching or resting at zero leaves EN only in periodic mode
         if (w_wr_ctrl)
            r_ctrl <= data_in[CTRL_W-1:0];
         else if (w_tick && (r_count <= DATA_W'(1)))
            r_ctrl[CTRL_EN] <= r_ctrl[CTRL_AUTO];

         if (w_expire)
            r_exp <= 1'b1;
         else if (w_wr_status && data_in[0])
            r_exp <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdy      <= 1'b0;
         r_data_out <= '0;
         r_irq      <= 1'b0;
      end else begin
         r_rdy      <= (w_state_nxt == ST_ACK);
         r_data_out <= (w_acc && !we && oe) ? w_rd_data : '0;
         r_irq      <= r_exp & r_ctrl[CTRL_IE];
      end
   end

   assign rdy      = r_rdy;
   assign data_out = r_data_out;
   assign irq      = r_irq;

endmodule

// File: tb/tb_limn2600_bus_timer.sv
// Directed bench for limn2600_bus_timer: one instance with PRESCALE=1, one with PRESCALE=16.
module tb_limn2600_bus_timer;

   localparam logic [31:0] BASE = 32'hF000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce1, ce16, we, oe;
   logic [31:0] addr, data_in;
   logic [31:0] dout1, dout16;
   logic        rdy1, rdy16, irq1, irq16;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   limn2600_bus_timer #(.BASE_ADDR(BASE), .PRESCALE(1)) u_dut1 (
      .clk(clk), .rst(rst), .ce(ce1), .we(we), .oe(oe), .addr(addr),
      .data_in(data_in), .data_out(dout1), .rdy(rdy1), .irq(irq1)
   );

   limn2600_bus_timer #(.BASE_ADDR(BASE), .PRESCALE(16)) u_dut16 (
      .clk(clk), .rst(rst), .ce(ce16), .we(we), .oe(oe), .addr(addr),
      .data_in(data_in), .data_out(dout16), .rdy(rdy16), .irq(irq16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Starts on a negedge, ends on a negedge with the FSM back in IDLE
   task automatic bus(input bit p16, input logic w, input logic [3:0] off,
                      input logic [31:0] d, output logic [31:0] rd);
      bit seen = 1'b0;
      rd      = '0;
      we      = w;
      oe      = 1'b1;
      addr    = BASE | 32'(off);
      data_in = d;
      if (p16) ce16 = 1'b1; else ce1 = 1'b1;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (p16 ? rdy16 : rdy1) begin
            seen = 1'b1;
            rd   = p16 ? dout16 : dout1;
         end
      end
      ce1  = 1'b0;
      ce16 = 1'b0;
      chk("bus_rdy_seen", 32'(seen), 32'd1);
      @(negedge clk);
   endtask

   task automatic wr(input bit p16, input logic [3:0] off, input logic [31:0] d);
      logic [31:0] dummy;
      bus(p16, 1'b1, off, d, dummy);
   endtask

   task automatic rd_chk(input bit p16, input logic [3:0] off, input logic [31:0] exp,
                         input string tag);
      logic [31:0] v;
      bus(p16, 1'b0, off, 32'h0, v);
      chk(tag, v, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          nrdy, first;
      logic [31:0] cap;
      logic [31:0] per_exp [4];
      per_exp = '{32'd2, 32'd1, 32'd2, 32'd1};

      // Reset with a request pending
      rst = 1'b0; ce1 = 1'b1; ce16 = 1'b1; we = 1'b0; oe = 1'b1;
      addr = BASE; data_in = '0;
      repeat (2) @(negedge clk);
      chk("rst_rdy",  32'({rdy16, rdy1}), 32'd0);
      chk("rst_irq",  32'({irq16, irq1}), 32'd0);
      chk("rst_dout", dout1 | dout16, 32'd0);
      ce1 = 1'b0; ce16 = 1'b0;
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      rd_chk(0, 4'h0, 32'd0, "rst_ctrl");
      rd_chk(0, 4'h4, 32'd0, "rst_reload");
      rd_chk(0, 4'h8, 32'd0, "rst_count");
      rd_chk(0, 4'hC, 32'd0, "rst_status");

      // Handshake with ce held 4 cycles
      nrdy = 0; first = -1;
      we = 1'b1; addr = BASE | 32'h4; data_in = 32'h1234; ce1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         if (rdy1) begin
            nrdy++;
            if (first < 0) first = i;
         end
      end
      ce1 = 1'b0;
      @(negedge clk);
      chk("hs_rdy_count", 32'(nrdy), 32'd1);
      chk("hs_latency", 32'(first), 32'd1);
      rd_chk(0, 4'h4, 32'h0000_1234, "hs_reload");

      // Outside the window: no rdy, no write
      nrdy = 0;
      we = 1'b1; addr = BASE + 32'h14; data_in = 32'hDEAD; ce1 = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (rdy1) nrdy++;
      end
      ce1 = 1'b0;
      @(negedge clk);
      chk("oow_rdy", 32'(nrdy), 32'd0);
      rd_chk(0, 4'h4, 32'h0000_1234, "oow_no_write");

      // One-shot, PRESCALE=1: ticks at the 3 edges after the CTRL write
      wr(0, 4'h8, 32'd3);
      wr(0, 4'h0, 32'h3);
      repeat (2) @(negedge clk);
      chk("os_irq_early", 32'(irq1), 32'd0);
      @(negedge clk);
      chk("os_irq", 32'(irq1), 32'd1);
      rd_chk(0, 4'hC, 32'd1, "os_exp");
      rd_chk(0, 4'h8, 32'd0, "os_count");
      rd_chk(0, 4'h0, 32'h2, "os_ctrl_en_off");
      wr(0, 4'hC, 32'd1);
      chk("os_irq_clr", 32'(irq1), 32'd0);
      rd_chk(0, 4'hC, 32'd0, "os_exp_clr");

      // Periodic, RELOAD=2: reads spaced 3 cycles apart walk through 2,1,2,1
      wr(0, 4'h4, 32'd2);
      wr(0, 4'h8, 32'd2);
      wr(0, 4'h0, 32'h7);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         rd_chk(0, 4'h8, per_exp[k], $sformatf("per_count%0d", k));
      end
      // This W1C lands on an expiry edge
      wr(0, 4'hC, 32'd1);
      rd_chk(0, 4'hC, 32'd1, "per_w1c_set_wins");
      chk("per_irq", 32'(irq1), 32'd1);
      wr(0, 4'h0, 32'h0);
      wr(0, 4'hC, 32'd1);
      rd_chk(0, 4'hC, 32'd0, "per_stop_exp");

      // Prescaler 16: expiry 16 cycles after the EN write
      wr(1, 4'h8, 32'd1);
      wr(1, 4'h0, 32'h3);
      repeat (15) @(negedge clk);
      chk("ps_irq_early", 32'(irq16), 32'd0);
      @(negedge clk);
      chk("ps_irq", 32'(irq16), 32'd1);
      wr(1, 4'hC, 32'd1);
      chk("ps_irq_clr", 32'(irq16), 32'd0);

      // COUNT write coinciding with a tick keeps the written value
      wr(1, 4'h8, 32'd10);
      wr(1, 4'h0, 32'h3);
      repeat (14) @(negedge clk);
      wr(1, 4'h8, 32'd5);
      rd_chk(1, 4'h8, 32'd5, "ps_cnt_write_wins");
      rd_chk(1, 4'hC, 32'd0, "ps_no_exp");

      // Reset while in ACK, ce held across release
      we = 1'b0; oe = 1'b1; addr = BASE | 32'h4; ce1 = 1'b1;
      @(negedge clk);
      chk("ra_rdy_pre", 32'(rdy1), 32'd1);
      #2 rst = 1'b0;
      #1 chk("ra_rdy_async", 32'(rdy1), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      nrdy = 0; cap = 32'hFFFF_FFFF;
      repeat (4) begin
         @(negedge clk);
         if (rdy1) begin
            nrdy++;
            cap = dout1;
         end
      end
      ce1 = 1'b0;
      @(negedge clk);
      chk("ra_rdy_count", 32'(nrdy), 32'd1);
      chk("ra_reload_cleared", cap, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
